// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared FSM encoding and sizing helpers for seq_mul_uni.
package seq_mul_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int steps(input int wb, input int bpc);
    return (wb + bpc - 1) / bpc;
  endfunction
endpackage

// File: rtl/mul_slice.sv
// mul_slice: one WIDTH_A x BITS_PER_CYCLE array slice computing a*b_chunk + window.
module mul_slice #(
  parameter int WIDTH_A = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [WIDTH_A-1:0]                a,
  input  logic [BITS_PER_CYCLE-1:0]         b_chunk,
  input  logic [WIDTH_A-1:0]                window,
  output logic [WIDTH_A+BITS_PER_CYCLE-1:0] sum
);
  logic [BITS_PER_CYCLE-1:0][WIDTH_A:0] row;
  assign row[0] = {1'b0, window} + {1'b0, a & {WIDTH_A{b_chunk[0]}}};
  // each row retires its lsb and passes the shifted partial sum down
  for (genvar i = 1; i < BITS_PER_CYCLE; i++) begin : g_row
    assign row[i] = {1'b0, row[i-1][WIDTH_A:1]} + {1'b0, a & {WIDTH_A{b_chunk[i]}}};
    assign sum[i-1] = row[i-1][0];
  end
  assign sum[WIDTH_A+BITS_PER_CYCLE-1:BITS_PER_CYCLE-1] = row[BITS_PER_CYCLE-1];
endmodule

// File: rtl/seq_mul_uni.sv
// seq_mul_uni: iterative unsigned multiplier consuming BITS_PER_CYCLE multiplier bits per cycle.
module seq_mul_uni
  import seq_mul_pkg::*;
#(
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 8,
  parameter int BITS_PER_CYCLE = 1,
  parameter int EARLY_EXIT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_A-1:0]         a,
  input  logic [WIDTH_B-1:0]         b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_A+WIDTH_B-1:0] p,
  output logic                       busy
);
  localparam int STEPS = steps(WIDTH_B, BITS_PER_CYCLE);
  localparam int CW = clog2(STEPS + 1);
  localparam int PB = STEPS * BITS_PER_CYCLE;
  localparam int PW = WIDTH_A + WIDTH_B;
  localparam int EW = WIDTH_A + PB;
  state_t state;
  logic [WIDTH_A-1:0] a_r;
  logic [PB-1:0] b_r;
  logic [PW-1:0] acc, acc_next;
  logic [CW-1:0] k;
  logic [31:0] shift;
  logic [EW-1:0] acc_ext, mask;
  logic [WIDTH_A-1:0] window;
  logic [BITS_PER_CYCLE-1:0] chunk;
  logic [WIDTH_A+BITS_PER_CYCLE-1:0] sum;
  logic rem_zero;
  assign shift = 32'(k) * 32'(BITS_PER_CYCLE);
  assign acc_ext = EW'(acc);
  assign mask = ~({EW{1'b1}} << shift);
  // bits of acc above the current offset never exceed WIDTH_A, so the slice sum cannot overflow
  assign window = WIDTH_A'(acc_ext >> shift);
  assign chunk = BITS_PER_CYCLE'(b_r >> shift);
  assign acc_next = PW'((acc_ext & mask) | (EW'(sum) << shift));
  assign rem_zero = (b_r >> shift) == '0;
  assign p = acc;
  mul_slice #(.WIDTH_A(WIDTH_A), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_slice (
    .a(a_r), .b_chunk(chunk), .window(window), .sum(sum)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      busy <= 1'b0;
      acc <= '0;
      k <= '0;
      a_r <= '0;
      b_r <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r <= a;
          b_r <= PB'(b);
          acc <= '0;
          k <= '0;
          state <= BUSY;
          in_ready <= 1'b0;
          busy <= 1'b1;
        end
        BUSY: if (EARLY_EXIT != 0 && rem_zero) begin
          state <= DONE;
          busy <= 1'b0;
          out_valid <= 1'b1;
        end else begin
          acc <= acc_next;
          k <= k + CW'(1);
          if (k == CW'(STEPS - 1)) begin
            state <= DONE;
            busy <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
          in_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mul_uni.sv
// tb_seq_mul_uni: several parameter sets of seq_mul_uni checked against a product/latency model.
module tb_seq_mul_uni;
  localparam int NC = 5;
  localparam int CWA[NC] = '{8, 8, 8, 8, 12};
  localparam int CWB[NC] = '{8, 8, 8, 12, 8};
  localparam int CBPC[NC] = '{1, 3, 1, 5, 2};
  localparam int CEE[NC] = '{0, 0, 1, 1, 0};
  localparam int DA[5] = '{255, 173, 0, 200, 0};
  localparam int DB[5] = '{255, 200, 99, 1, 0};
  localparam int DP[5] = '{65025, 34600, 0, 200, 0};
  typedef struct {
    longint unsigned p;
    int e;
    int lat;
    bit seen;
  } exp_t;
  logic clk = 0;
  int n_cmp = 0, n_fail = 0, done_cnt = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int cfg, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cfg%0d: got %0d want %0d", nm, cfg, act, exp);
    end
  endtask
  function automatic int lat_of(input int wb, input int bpc, input int ee, input longint unsigned bv);
    int st = (wb + bpc - 1) / bpc;
    int nb = 0;
    int need;
    for (int i = 0; i < wb; i++) if (bv[i]) nb = i + 1;
    need = (nb + bpc - 1) / bpc;
    return (ee != 0) ? ((need + 1 < st) ? need + 1 : st) : st;
  endfunction
  for (genvar g = 0; g < NC; g++) begin : g_cfg
    localparam int WA = CWA[g];
    localparam int WB = CWB[g];
    localparam int BPC = CBPC[g];
    localparam int EE = CEE[g];
    localparam int PW = WA + WB;
    logic rst = 1, in_valid = 0, out_ready = 1, or_man = 0;
    logic in_ready, out_valid, busy;
    logic [WA-1:0] a = '0;
    logic [WB-1:0] b = '0;
    logic [PW-1:0] p;
    logic [63:0] last_p = '0;
    int mode = 0, ec = 0, xfers = 0, accepts = 0, dropped = 0;
    bit rflag = 0, xflag = 0, hold = 0;
    exp_t q[$];
    seq_mul_uni #(.WIDTH_A(WA), .WIDTH_B(WB), .BITS_PER_CYCLE(BPC), .EARLY_EXIT(EE)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
    );
    always @(posedge clk) ec <= ec + 1;
    always @(posedge clk) begin
      #2;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 1) == 1) : or_man;
    end
    always @(negedge clk) begin
      if (rflag) begin
        chk("rst_out_valid", g, out_valid, 0);
        chk("rst_in_ready", g, in_ready, 1);
        chk("rst_busy", g, busy, 0);
        chk("rst_p", g, p, 0);
      end else begin
        if (xflag) chk("idle_after_xfer", g, {in_ready, out_valid}, 2'b10);
        if (hold) chk("valid_hold", g, out_valid, 1);
        chk("ready_valid_excl", g, in_ready & out_valid, 0);
        chk("busy", g, busy, !in_ready && !out_valid);
        if (out_valid && q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_valid cfg%0d: got out_valid=1 want no pending product", g);
        end else if (out_valid) begin
          chk("product", g, p, q[0].p);
          if (!q[0].seen) begin
            chk("latency", g, 64'(ec - q[0].e), 64'(q[0].lat));
            q[0].seen = 1;
          end
          if (out_ready && !rst) begin
            last_p = 64'(p);
            void'(q.pop_front());
            xfers++;
          end
        end
      end
      rflag = rst;
      xflag = !rst && out_valid && out_ready;
      hold = !rst && out_valid && !out_ready;
      if (rst) begin
        dropped += q.size();
        q.delete();
      end else if (in_valid && in_ready) begin
        q.push_back('{64'(a) * 64'(b), ec + 1, lat_of(WB, BPC, EE, 64'(b)), 1'b0});
        accepts++;
      end
    end
    task automatic send(input logic [31:0] x, input logic [31:0] y);
      bit ok = 0;
      in_valid = 1;
      a = x[WA-1:0];
      b = y[WB-1:0];
      for (int t = 0; t < 300; t++) begin
        @(negedge clk);
        if (in_ready) begin
          ok = 1;
          break;
        end
      end
      if (!ok) begin
        n_cmp++;
        n_fail++;
        $display("FAIL accept_timeout cfg%0d: got in_ready=0 want 1 within 300 cycles", g);
      end
      @(posedge clk);
      #1 in_valid = 0;
    endtask
    task automatic drain();
      for (int t = 0; t < 300; t++) begin
        @(negedge clk);
        if (in_ready && q.size() == 0) break;
      end
      if (!(in_ready && q.size() == 0)) begin
        n_cmp++;
        n_fail++;
        $display("FAIL drain_timeout cfg%0d: got pending=%0d want 0", g, q.size());
      end
      @(posedge clk);
      #1;
    endtask
    initial begin
      int x0;
      logic [31:0] ra, rb;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      for (int i = 0; i < 5; i++) begin
        send(32'(DA[i]), 32'(DB[i]));
        drain();
        chk("directed", g, last_p, 64'(DP[i]));
      end
      mode = 2;
      or_man = 0;
      send(77, 3);
      for (int t = 0; t < 100 && !out_valid; t++) @(negedge clk);
      chk("bp_valid", g, out_valid, 1);
      @(posedge clk);
      #1 in_valid = 1;
      a = 1;
      b = 1;
      @(posedge clk);
      #1 in_valid = 0;
      repeat (3) @(posedge clk);
      #1 x0 = xfers;
      or_man = 1;
      drain();
      chk("bp_single_xfer", g, 64'(xfers - x0), 1);
      chk("bp_product", g, last_p, 231);
      mode = 0;
      send(255, 255);
      @(posedge clk);
      #1 rst = 1;
      @(posedge clk);
      #1 rst = 0;
      send(12, 11);
      drain();
      chk("after_reset", g, last_p, 132);
      mode = 1;
      for (int i = 0; i < 250; i++) begin
        ra = $urandom;
        rb = $urandom & ((32'd1 << WB) - 1);
        rb = rb >> $urandom_range(0, WB);
        send(ra, rb);
      end
      drain();
      mode = 0;
      chk("queue_empty", g, 64'(q.size()), 0);
      chk("xfer_count", g, 64'(xfers), 64'(accepts - dropped));
      done_cnt++;
    end
  end
  initial begin
    for (int t = 0; t < 90000; t++) begin
      if (done_cnt == NC) break;
      @(posedge clk);
    end
    if (done_cnt != NC) begin
      n_cmp++;
      n_fail++;
      $display("FAIL global_timeout: got %0d configs done want %0d", done_cnt, NC);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
